// File: rtl/message_extractor_pw.sv
// message_extractor_pw: parses an Avalon-ST packet stream carrying a 16-bit
// message count followed by length-prefixed messages. It emits one
// right-justified message per output transfer, with a byte mask.
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   in_valid/in_ready           input beat handshake (in_ready is combinational)
//   in_startofpacket/endofpacket packet framing
//   in_error                    packet error, sampled on the EOP beat
//   in_data/in_empty            big-endian lanes, unused trailing lanes on EOP
//   out_valid/out_ready         message handshake
//   out_data/out_bytemask       payload (last byte at [7:0]) and valid-byte mask
//   out_error                   message completed in an errored EOP beat
//   drop_cnt                    saturating count of discarded messages
module message_extractor_pw #(
    parameter int unsigned IN_BYTES      = 8,
    parameter int unsigned MAX_MSG_BYTES = 32,
    parameter int unsigned MIN_MSG_BYTES = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_startofpacket,
    input  logic                           in_endofpacket,
    input  logic                           in_error,
    input  logic [IN_BYTES*8-1:0]          in_data,
    input  logic [$clog2(IN_BYTES)-1:0]    in_empty,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAX_MSG_BYTES*8-1:0]     out_data,
    output logic [MAX_MSG_BYTES-1:0]       out_bytemask,
    output logic                           out_error,
    output logic [15:0]                    drop_cnt
);

    localparam int unsigned DW    = IN_BYTES * 8;
    localparam int unsigned AW    = MAX_MSG_BYTES * 8;
    localparam logic [15:0] MIN_L = 16'(MIN_MSG_BYTES);
    localparam logic [15:0] MAX_L = 16'(MAX_MSG_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_PAY,
        S_DISCARD
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              msg_cnt_q, msg_cnt_d;
    logic [15:0]              rem_q, rem_d;      // holds length while parsing, then bytes left
    logic [AW-1:0]            acc_q, acc_d;
    logic [MAX_MSG_BYTES-1:0] mask_q, mask_d;
    logic                     out_valid_q, out_valid_d;
    logic [AW-1:0]            out_data_q, out_data_d;
    logic [MAX_MSG_BYTES-1:0] out_mask_q, out_mask_d;
    logic                     out_error_q, out_error_d;
    logic [15:0]              drop_q, drop_d;
    logic                     beat_acc;
    logic                     lane_ok;
    logic [7:0]               lane_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_ready     = !out_valid_q || out_ready;
    assign beat_acc     = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_bytemask = out_mask_q;
    assign out_error    = out_error_q;
    assign drop_cnt     = drop_q;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            msg_cnt_q   <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_error_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            msg_cnt_q   <= msg_cnt_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_error_q <= out_error_d;
            drop_q      <= drop_d;
        end
    end

    // Walk the lanes of an accepted beat through the byte-parse FSM
    always_comb begin
        state_d     = state_q;
        msg_cnt_d   = msg_cnt_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_error_d = out_error_q;
        drop_d      = drop_q;
        lane_ok     = 1'b0;
        lane_byte   = '0;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (beat_acc) begin
            // SOP always restarts parsing; a message begun but unfinished is lost
            if (in_startofpacket) begin
                if (state_d == S_PAY || state_d == S_LEN_LO) begin
                    drop_d = sat_inc(drop_d);
                end
                state_d = S_CNT_HI;
            end

            for (int unsigned i = 0; i < IN_BYTES; i++) begin
                lane_ok   = !in_endofpacket || (i < (IN_BYTES - 32'(in_empty)));
                lane_byte = in_data[DW-1-8*i -: 8];
                if (lane_ok) begin
                    case (state_d)
                        S_CNT_HI: begin
                            msg_cnt_d = {lane_byte, 8'h00};
                            state_d   = S_CNT_LO;
                        end
                        S_CNT_LO: begin
                            msg_cnt_d = {msg_cnt_d[15:8], lane_byte};
                            state_d   = (msg_cnt_d == 16'd0) ? S_DISCARD : S_LEN_HI;
                        end
                        S_LEN_HI: begin
                            rem_d   = {lane_byte, 8'h00};
                            state_d = S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            rem_d = {rem_d[15:8], lane_byte};
                            if (rem_d < MIN_L || rem_d > MAX_L) begin
                                drop_d  = sat_inc(drop_d);
                                state_d = S_DISCARD;
                            end else begin
                                acc_d   = '0;
                                mask_d  = '0;
                                state_d = S_PAY;
                            end
                        end
                        S_PAY: begin
                            acc_d  = {acc_d[AW-9:0], lane_byte};
                            mask_d = {mask_d[MAX_MSG_BYTES-2:0], 1'b1};
                            rem_d  = rem_d - 16'd1;
                            if (rem_d == 16'd0) begin
                                out_valid_d = 1'b1;
                                out_data_d  = acc_d;
                                out_mask_d  = mask_d;
                                out_error_d = in_error && in_endofpacket;
                                msg_cnt_d   = msg_cnt_d - 16'd1;
                                state_d     = (msg_cnt_d == 16'd0) ? S_DISCARD : S_LEN_HI;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // EOP closes the packet; an outstanding message is counted as dropped
            if (in_endofpacket) begin
                if (state_d == S_LEN_HI || state_d == S_LEN_LO || state_d == S_PAY) begin
                    drop_d = sat_inc(drop_d);
                end
                state_d = S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_message_extractor_pw.sv
// Randomized scoreboard bench for message_extractor_pw. Packets are built as
// byte lists; a packet-level reference model derives the expected messages and
// drop count, and a monitor compares each output transfer against the queue.
module tb_message_extractor_pw;

    localparam int IB = 8;
    localparam int MX = 32;
    localparam int MN = 8;
    localparam int EW = $clog2(IB);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_startofpacket;
    logic              in_endofpacket;
    logic              in_error;
    logic [IB*8-1:0]   in_data;
    logic [EW-1:0]     in_empty;
    logic              out_valid;
    logic              out_ready;
    logic [MX*8-1:0]   out_data;
    logic [MX-1:0]     out_bytemask;
    logic              out_error;
    logic [15:0]       drop_cnt;

    typedef struct {
        logic [MX*8-1:0] data;
        logic [MX-1:0]   mask;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   exp_drop = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    message_extractor_pw #(.IN_BYTES(IB), .MAX_MSG_BYTES(MX), .MIN_MSG_BYTES(MN)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_error         (in_error),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_bytemask     (out_bytemask),
        .out_error        (out_error),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [MX*8-1:0] act, input logic [MX*8-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Packet-level reference: walk the byte list message by message
    task automatic model_packet(input logic [7:0] pkt[$], input bit err);
        int   n;
        int   pos;
        int   cnt;
        int   len;
        exp_t e;
        n = pkt.size();
        if (n < 2) return;
        cnt = int'({pkt[0], pkt[1]});
        pos = 2;
        while (cnt > 0) begin
            if (pos + 2 > n) begin exp_drop++; return; end
            len = int'({pkt[pos], pkt[pos+1]});
            pos += 2;
            if (len < MN || len > MX) begin exp_drop++; return; end
            if (pos + len > n) begin exp_drop++; return; end
            e.data = '0;
            e.mask = '0;
            for (int k = 0; k < len; k++) begin
                e.data    = {e.data[MX*8-9:0], pkt[pos+k]};
                e.mask[k] = 1'b1;
            end
            pos += len;
            e.err = err && (((pos - 1) / IB) == ((n - 1) / IB));
            exp_q.push_back(e);
            cnt--;
        end
    endtask

    task automatic send_beat(input logic [IB*8-1:0] d, input bit sop, input bit eop,
                             input int emp, input bit err);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        in_valid         = 1'b1;
        in_data          = d;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = EW'(emp);
        in_error         = err;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 2000) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: in_ready stuck low after %0d cycles", t);
                acc = 1'b1;
            end
        end
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] pkt[$], input bit err, input bit gaps);
        int              n;
        int              nb;
        int              idx;
        logic [IB*8-1:0] d;
        logic [7:0]      b;
        n  = pkt.size();
        nb = (n + IB - 1) / IB;
        model_packet(pkt, err);
        for (int bt = 0; bt < nb; bt++) begin
            for (int l = 0; l < IB; l++) begin
                idx = bt * IB + l;
                b   = (idx < n) ? pkt[idx] : 8'($urandom);
                d[IB*8-1-8*l -: 8] = b;
            end
            if (gaps && ($urandom % 4 == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(d, bt == 0, bt == nb - 1, (IB - n % IB) % IB, err && (bt == nb - 1));
        end
        check("drop_cnt", {240'd0, drop_cnt}, {240'd0, 16'(exp_drop)});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d messages still expected, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plan_pkt(output logic [7:0] p[$]);
        p = {8'h00, 8'h02, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h0A, 8'h11, 8'h12,
             8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    endtask

    task automatic gen_pkt(output logic [7:0] p[$]);
        int c;
        int r;
        int len;
        int npay;
        p.delete();
        c = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 3));
        p.push_back(8'h00);
        p.push_back(8'(c));
        for (int m = 0; m < c; m++) begin
            r = int'($urandom % 10);
            if (r == 0)      len = int'($urandom_range(1, MN - 1));
            else if (r == 1) len = int'($urandom_range(MX + 1, 300));
            else             len = int'($urandom_range(MN, MX));
            p.push_back(8'(len >> 8));
            p.push_back(8'(len));
            npay = (len <= MX) ? len : int'($urandom_range(0, 5));
            for (int k = 0; k < npay; k++) p.push_back(8'($urandom));
        end
        if ($urandom % 4 == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) p.push_back(8'($urandom));
        end
        if ($urandom % 4 == 0 && p.size() > 1) begin
            p = p[0:int'($urandom_range(0, p.size() - 2))];
        end
    endtask

    // Output ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom % 3) != 0;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on transfer, hold check while stalled
    logic [MX*8-1:0] prev_data;
    logic [MX-1:0]   prev_mask;
    logic            prev_err;
    bit              stalled = 1'b0;
    exp_t            got;

    always @(negedge clk) begin
        if (reset_n) begin
            if (stalled) begin
                check("stall_valid", {255'd0, out_valid}, {255'd0, 1'b1});
                check("stall_data", out_data, prev_data);
                check("stall_mask", {224'd0, out_bytemask}, {224'd0, prev_mask});
                check("stall_err", {255'd0, out_error}, {255'd0, prev_err});
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_mask = out_bytemask;
            prev_err  = out_error;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg: data=%0h mask=%0h, required no message",
                             out_data, out_bytemask);
                end else begin
                    got = exp_q.pop_front();
                    check("msg_data", out_data, got.data);
                    check("msg_mask", {224'd0, out_bytemask}, {224'd0, got.mask});
                    check("msg_err", {255'd0, out_error}, {255'd0, got.err});
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]      p[$];
        logic [IB*8-1:0] d;
        int              t;

        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 1'b0;
        in_data          = '0;
        in_empty         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {255'd0, out_valid}, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_mask", {224'd0, out_bytemask}, '0);
        check("rst_out_error", {255'd0, out_error}, '0);
        check("rst_drop_cnt", {240'd0, drop_cnt}, '0);
        check("rst_in_ready", {255'd0, in_ready}, {255'd0, 1'b1});
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-message packet
        plan_pkt(p);
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // Length field split across beats (LEN_HI in lane 7)
        p = {8'h00, 8'h02, 8'h00, 8'h0B};
        for (int k = 0; k < 11; k++) p.push_back(8'(8'hA0 + k));
        p.push_back(8'h00);
        p.push_back(8'h09);
        for (int k = 0; k < 9; k++) p.push_back(8'(8'hC0 + k));
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // Backpressure: hold out_ready low while the first message waits
        rdy_mode = 2;
        @(posedge clk);
        #1;
        plan_pkt(p);
        fork
            send_packet(p, 1'b0, 1'b0);
            begin
                t = 0;
                while (!out_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_wait: out_valid=0 after %0d cycles, required 1", t);
                end
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", {255'd0, in_ready}, '0);
                end
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Oversized length: dropped, rest of packet ignored, next parses
        p = {8'h00, 8'h01, 8'h00, 8'h28};
        for (int k = 0; k < 40; k++) p.push_back(8'($urandom));
        send_packet(p, 1'b0, 1'b0);
        plan_pkt(p);
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // EOP with 3 payload bytes outstanding (empty=2)
        p = {8'h00, 8'h01, 8'h00, 8'h0D};
        for (int k = 0; k < 10; k++) p.push_back(8'($urandom));
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // Error on the EOP beat that completes a message
        plan_pkt(p);
        send_packet(p, 1'b1, 1'b0);
        wait_drain();

        // SOP while mid-payload abandons the partial message
        send_beat({8'h00, 8'h01, 8'h00, 8'h14, 32'hDEADBEEF}, 1'b1, 1'b0, 0, 1'b0);
        send_beat(64'h0123456789ABCDEF, 1'b0, 1'b0, 0, 1'b0);
        exp_drop++;
        plan_pkt(p);
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // Reset mid-payload: all state cleared, tail ignored
        send_beat({8'h00, 8'h01, 8'h00, 8'h14, 32'h55667788}, 1'b1, 1'b0, 0, 1'b0);
        send_beat(64'h8877665544332211, 1'b0, 1'b0, 0, 1'b0);
        reset_n = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        #1;
        check("mid_rst_valid", {255'd0, out_valid}, '0);
        check("mid_rst_data", out_data, '0);
        check("mid_rst_mask", {224'd0, out_bytemask}, '0);
        check("mid_rst_drop", {240'd0, drop_cnt}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        d = {8'h00, 8'h01, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
        send_beat(d, 1'b0, 1'b0, 0, 1'b0);
        send_beat(64'h0506070809101112, 1'b0, 1'b1, 0, 1'b0);
        check("tail_drop", {240'd0, drop_cnt}, '0);
        plan_pkt(p);
        send_packet(p, 1'b0, 1'b0);
        wait_drain();

        // Randomized packets with random backpressure and idle junk beats
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom % 6 == 0) begin
                d = {$urandom, $urandom};
                send_beat(d, 1'b0, ($urandom % 2) == 1, 0, 1'b0);
            end
            gen_pkt(p);
            send_packet(p, ($urandom % 3) == 0, 1'b1);
        end
        rdy_mode = 0;
        wait_drain();
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
